pll_param_responder: RTL and testbench

PLL_PARAM_RESPONDER -- requirements
Module: pll_param_responder

---
 rtl/pll_param_responder.sv | 179 +++++++++++++++++
 tb/tb_pll_param_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_param_responder.sv
// pll_param_responder: holds the PLL counter parameters (N, M, C0 high/low)
// in shadow registers and serialises them onto the PLL scan chain on request.
// Optional build macro PLL_PARAM_RESPONDER_READBACK_EN enables read_param
// readback on data_out. Without it, read_param performs no read and
// data_out is tied to zero.
module pll_param_responder #(
    parameter int unsigned WRITE_BUSY = 2,
    parameter int unsigned SCAN_LEN   = 36
) (
    input  logic       clock_ctr,
    input  logic       sys_reset,
    input  logic       write_param,
    input  logic       read_param,
    input  logic       reconfig,
    input  logic [3:0] counter_type,
    input  logic [2:0] counter_param,
    input  logic [8:0] data_in,
    output logic       busy,
    output logic [8:0] data_out,
    output logic       scanclk_en,
    output logic       scandata,
    output logic       configupdate,
    output logic       param_error
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [3:0] WAIT_INIT  = 4'(WRITE_BUSY - 1);
    localparam logic [5:0] SHIFT_LAST = 6'(SCAN_LEN - 1);

    logic [1:0]          state;
    logic [3:0]          wait_cnt;
    logic [5:0]          shift_cnt;
    logic [SCAN_LEN-1:0] shift_reg;
    logic [SCAN_LEN-1:0] chain;
    logic [8:0]          reg_n;
    logic [8:0]          reg_m;
    logic [8:0]          reg_c0h;
    logic [8:0]          reg_c0l;
    logic                sel_n;
    logic                sel_m;
    logic                sel_c0h;
    logic                sel_c0l;
    logic                addr_valid;
    logic                any_strobe;

    // Chain order is M, N, C0 high, C0 low, each MSB first.
    assign chain      = {reg_m, reg_n, reg_c0h, reg_c0l};
    assign any_strobe = write_param | read_param | reconfig;

    // Decode the counter_type/counter_param pair into a shadow register select.
    always_comb begin
        sel_n      = (counter_type == 4'd0) && (counter_param == 3'd7);
        sel_m      = (counter_type == 4'd1) && (counter_param == 3'd7);
        sel_c0h    = (counter_type == 4'd4) && (counter_param == 3'd0);
        sel_c0l    = (counter_type == 4'd4) && (counter_param == 3'd1);
        addr_valid = sel_n | sel_m | sel_c0h | sel_c0l;
    end

    // Shadow registers load only on an accepted write in IDLE.
    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset) begin
            reg_n   <= 9'd1;
            reg_m   <= 9'd12;
            reg_c0h <= 9'd6;
            reg_c0l <= 9'd6;
        end else if ((state == ST_IDLE) && write_param) begin
            if (sel_n)   reg_n   <= data_in;
            if (sel_m)   reg_m   <= data_in;
            if (sel_c0h) reg_c0h <= data_in;
            if (sel_c0l) reg_c0l <= data_in;
        end
    end

    // Control FSM with registered outputs; strobes outside IDLE are rejected.
    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            wait_cnt     <= '0;
            shift_cnt    <= '0;
            shift_reg    <= '0;
            scanclk_en   <= 1'b0;
            scandata     <= 1'b0;
            configupdate <= 1'b0;
            param_error  <= 1'b0;
        end else begin
            param_error  <= 1'b0;
            configupdate <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (write_param) begin
                        state       <= ST_WAIT;
                        busy        <= 1'b1;
                        wait_cnt    <= WAIT_INIT;
                        param_error <= ~addr_valid;
                    end else if (reconfig) begin
                        // The first chain bit is presented straight from the
                        // shadow registers; shift_reg holds the remainder.
                        state      <= ST_SHIFT;
                        busy       <= 1'b1;
                        shift_cnt  <= '0;
                        scanclk_en <= 1'b1;
                        scandata   <= chain[SCAN_LEN-1];
                        shift_reg  <= {chain[SCAN_LEN-2:0], 1'b0};
                    end
`ifdef PLL_PARAM_RESPONDER_READBACK_EN
                    else if (read_param) begin
                        state       <= ST_WAIT;
                        busy        <= 1'b1;
                        wait_cnt    <= '0;
                        param_error <= ~addr_valid;
                    end
`endif
                end
                ST_WAIT: begin
                    param_error <= any_strobe;
                    if (wait_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    param_error <= any_strobe;
                    if (shift_cnt == SHIFT_LAST) begin
                        state        <= ST_UPDATE;
                        scanclk_en   <= 1'b0;
                        scandata     <= 1'b0;
                        configupdate <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + 6'd1;
                        scandata  <= shift_reg[SCAN_LEN-1];
                        shift_reg <= {shift_reg[SCAN_LEN-2:0], 1'b0};
                    end
                end
                ST_UPDATE: begin
                    param_error <= any_strobe;
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    shift_cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_PARAM_RESPONDER_READBACK_EN
    logic [8:0] rd_data;

    // Select the addressed shadow register for readback; unlisted reads give 0.
    always_comb begin
        rd_data = '0;
        if (sel_n)   rd_data = reg_n;
        if (sel_m)   rd_data = reg_m;
        if (sel_c0h) rd_data = reg_c0h;
        if (sel_c0l) rd_data = reg_c0l;
    end

    // data_out captures a read only when no higher-priority strobe is present.
    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset) begin
            data_out <= '0;
        end else if ((state == ST_IDLE) && read_param && !write_param && !reconfig) begin
            data_out <= rd_data;
        end
    end
`else
    assign data_out = '0;
`endif

endmodule

// File: tb/tb_pll_param_responder.sv
// Testbench for pll_param_responder: randomized and directed stimulus checked
// against a register-level model of the shadow registers and scan stream.
module tb_pll_param_responder;

    localparam int WB = 2;

    logic       clock_ctr     = 1'b0;
    logic       sys_reset     = 1'b1;
    logic       write_param   = 1'b0;
    logic       read_param    = 1'b0;
    logic       reconfig      = 1'b0;
    logic [3:0] counter_type  = '0;
    logic [2:0] counter_param = '0;
    logic [8:0] data_in       = '0;
    logic       busy;
    logic [8:0] data_out;
    logic       scanclk_en;
    logic       scandata;
    logic       configupdate;
    logic       param_error;

    int checks = 0;
    int errors = 0;

    // Model: index 0=N, 1=M, 2=C0H, 3=C0L
    logic [8:0] mdl [4];
    logic [8:0] mdl_dout;

    pll_param_responder #(.WRITE_BUSY(WB), .SCAN_LEN(36)) dut (
        .clock_ctr    (clock_ctr),
        .sys_reset    (sys_reset),
        .write_param  (write_param),
        .read_param   (read_param),
        .reconfig     (reconfig),
        .counter_type (counter_type),
        .counter_param(counter_param),
        .data_in      (data_in),
        .busy         (busy),
        .data_out     (data_out),
        .scanclk_en   (scanclk_en),
        .scandata     (scandata),
        .configupdate (configupdate),
        .param_error  (param_error)
    );

    always #5 clock_ctr = ~clock_ctr;

    task automatic step();
        @(posedge clock_ctr);
        #1;
    endtask

    function automatic int addr_idx(input logic [3:0] t, input logic [2:0] p);
        if (t == 4'd0 && p == 3'd7) return 0;
        if (t == 4'd1 && p == 3'd7) return 1;
        if (t == 4'd4 && p == 3'd0) return 2;
        if (t == 4'd4 && p == 3'd1) return 3;
        return -1;
    endfunction

    function automatic logic [35:0] mdl_stream();
        return {mdl[1], mdl[0], mdl[2], mdl[3]};
    endfunction

    task automatic mdl_reset();
        mdl[0] = 9'd1; mdl[1] = 9'd12; mdl[2] = 9'd6; mdl[3] = 9'd6;
        mdl_dout = '0;
    endtask

    task automatic valid_addr(input int k, output logic [3:0] t, output logic [2:0] p);
        case (k)
            0: begin t = 4'd0; p = 3'd7; end
            1: begin t = 4'd1; p = 3'd7; end
            2: begin t = 4'd4; p = 3'd0; end
            default: begin t = 4'd4; p = 3'd1; end
        endcase
    endtask

    // Issue one write, then count busy cycles and param_error pulses.
    task automatic issue_write(input logic [3:0] t, input logic [2:0] p, input logic [8:0] d,
                               output logic perr1, output int bcyc, output int perr_cnt);
        int idx;
        counter_type = t; counter_param = p; data_in = d; write_param = 1'b1;
        step();
        write_param = 1'b0;
        perr1 = param_error; perr_cnt = 0; bcyc = 0;
        while (busy && bcyc < 20) begin
            if (param_error) perr_cnt++;
            bcyc++;
            step();
        end
        if (param_error) perr_cnt++;
        idx = addr_idx(t, p);
        if (idx >= 0) mdl[idx] = d;
    endtask

    // Issue a reconfig and record the observed stream and its timing.
    task automatic capture_reconfig(input logic rd, input int inj_cyc, input logic [3:0] it,
                                    input logic [2:0] ip, input logic [8:0] id,
                                    output logic [35:0] stream, output int nbits,
                                    output int first_en, output int last_en,
                                    output int cu_cyc, output int cu_cnt,
                                    output int idle_cyc, output int perr_cyc, output int viol);
        reconfig = 1'b1; read_param = rd;
        step();
        reconfig = 1'b0; read_param = 1'b0;
        stream = '0; nbits = 0; first_en = 0; last_en = 0; cu_cyc = 0; cu_cnt = 0;
        idle_cyc = 0; perr_cyc = 0; viol = 0;
        for (int c = 1; c <= 60; c++) begin
            if (scanclk_en) begin
                stream = {stream[34:0], scandata};
                nbits++;
                if (first_en == 0) first_en = c;
                last_en = c;
            end else if (scandata) begin
                viol++;
            end
            if (configupdate) begin
                cu_cnt++;
                if (cu_cyc == 0) cu_cyc = c;
                if (scanclk_en) viol++;
            end
            if (param_error && perr_cyc == 0) perr_cyc = c;
            if (!busy) begin
                idle_cyc = c;
                break;
            end
            if (c == inj_cyc) begin
                counter_type = it; counter_param = ip; data_in = id; write_param = 1'b1;
            end
            step();
            write_param = 1'b0;
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({busy, scanclk_en, scandata, configupdate, param_error, data_out} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp 0",
                     {busy, scanclk_en, scandata, configupdate, param_error, data_out});
        end
        write_param = 1'b1; reconfig = 1'b1;
        step();
        write_param = 1'b0; reconfig = 1'b0;
        checks++;
        if ({busy, scanclk_en} !== 2'b00) begin
            errors++; $display("FAIL reset_hold_busy: got %b exp 00", {busy, scanclk_en});
        end
        sys_reset = 1'b0;
        mdl_reset();
    endtask

    task automatic test_default_stream();
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s !== mdl_stream()) begin errors++; $display("FAIL default_stream: got %h exp %h", s, mdl_stream()); end
        checks++; if (nb !== 36 || fe !== 1 || le !== 36) begin errors++; $display("FAIL default_scan_window: got n=%0d first=%0d last=%0d exp 36/1/36", nb, fe, le); end
        checks++; if (cc !== 37 || cn !== 1) begin errors++; $display("FAIL default_configupdate: got cyc=%0d cnt=%0d exp 37/1", cc, cn); end
        checks++; if (ic !== 38) begin errors++; $display("FAIL default_busy_drop: got %0d exp 38", ic); end
        checks++; if (v !== 0 || pc !== 0) begin errors++; $display("FAIL default_idle_rules: got viol=%0d perr=%0d exp 0/0", v, pc); end
    endtask

    task automatic test_write_m();
        logic pe; int bc, pn;
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        issue_write(4'd1, 3'd7, 9'd20, pe, bc, pn);
        checks++; if (pe !== 1'b0 || pn !== 0) begin errors++; $display("FAIL write_m_perr: got %0d/%0d exp 0/0", pe, pn); end
        checks++; if (bc !== WB) begin errors++; $display("FAIL write_m_busy: got %0d exp %0d", bc, WB); end
        capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s[35:27] !== 9'd20) begin errors++; $display("FAIL write_m_first9: got %b exp %b", s[35:27], 9'd20); end
        checks++; if (s !== mdl_stream()) begin errors++; $display("FAIL write_m_stream: got %h exp %h", s, mdl_stream()); end
    endtask

    task automatic test_bad_write();
        logic pe; int bc, pn;
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        issue_write(4'd2, 3'd3, 9'h1AB, pe, bc, pn);
        checks++; if (pe !== 1'b1 || pn !== 1) begin errors++; $display("FAIL bad_write_perr: got %0d/%0d exp 1/1", pe, pn); end
        checks++; if (bc !== WB) begin errors++; $display("FAIL bad_write_busy: got %0d exp %0d", bc, WB); end
        capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s !== mdl_stream()) begin errors++; $display("FAIL bad_write_stream: got %h exp %h", s, mdl_stream()); end
    endtask

    task automatic test_busy_reject();
        logic [35:0] s, s2; int nb, fe, le, cc, cn, ic, pc, v;
        capture_reconfig(1'b0, 10, 4'd1, 3'd7, 9'h1FF, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (pc !== 11) begin errors++; $display("FAIL shift_reject_perr: got cyc %0d exp 11", pc); end
        checks++; if (s !== mdl_stream() || nb !== 36 || cc !== 37) begin errors++; $display("FAIL shift_reject_stream: got %h n=%0d cu=%0d exp %h 36 37", s, nb, cc, mdl_stream()); end
        capture_reconfig(1'b0, 0, '0, '0, '0, s2, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s2 !== mdl_stream()) begin errors++; $display("FAIL repeat_stream: got %h exp %h", s2, mdl_stream()); end
    endtask

    task automatic test_back_to_back();
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        counter_type = 4'd0; counter_param = 3'd7; data_in = 9'd3; write_param = 1'b1;
        step();
        write_param = 1'b0; mdl[0] = 9'd3;
        reconfig = 1'b1;
        step();
        reconfig = 1'b0;
        checks++; if ({param_error, scanclk_en, busy} !== 3'b101) begin errors++; $display("FAIL wait_reject: got %b exp 101", {param_error, scanclk_en, busy}); end
        step();
        checks++; if ({param_error, scanclk_en, busy} !== 3'b000) begin errors++; $display("FAIL wait_done: got %b exp 000", {param_error, scanclk_en, busy}); end
        capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s !== mdl_stream() || fe !== 1) begin errors++; $display("FAIL b2b_stream: got %h first=%0d exp %h 1", s, fe, mdl_stream()); end
    endtask

    task automatic test_priority();
        int bc;
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        counter_type = 4'd4; counter_param = 3'd0; data_in = 9'h055;
        write_param = 1'b1; reconfig = 1'b1; read_param = 1'b1;
        step();
        write_param = 1'b0; reconfig = 1'b0; read_param = 1'b0; mdl[2] = 9'h055;
        checks++; if ({busy, scanclk_en, param_error} !== 3'b100) begin errors++; $display("FAIL prio_write_wins: got %b exp 100", {busy, scanclk_en, param_error}); end
        bc = 0;
        while (busy && bc < 20) begin bc++; step(); end
        checks++; if (bc !== WB) begin errors++; $display("FAIL prio_write_busy: got %0d exp %0d", bc, WB); end
        capture_reconfig(1'b1, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s !== mdl_stream() || pc !== 0 || ic !== 38) begin errors++; $display("FAIL prio_reconfig_wins: got %h perr=%0d idle=%0d exp %h 0 38", s, pc, ic, mdl_stream()); end
        checks++; if (data_out !== mdl_dout) begin errors++; $display("FAIL prio_dout: got %h exp %h", data_out, mdl_dout); end
    endtask

    task automatic test_reset_mid_shift();
        logic pe; int bc, pn, cuseen;
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        issue_write(4'd4, 3'd1, 9'h1F0, pe, bc, pn);
        reconfig = 1'b1;
        step();
        reconfig = 1'b0;
        for (int c = 1; c < 20; c++) step();
        checks++; if (scanclk_en !== 1'b1) begin errors++; $display("FAIL mid_shift_active: got %b exp 1", scanclk_en); end
        sys_reset = 1'b1;
        #1;
        checks++; if ({scanclk_en, scandata, busy, configupdate} !== 4'b0000) begin errors++; $display("FAIL async_reset: got %b exp 0000", {scanclk_en, scandata, busy, configupdate}); end
        cuseen = 0;
        for (int c = 0; c < 3; c++) begin step(); if (configupdate || scanclk_en) cuseen++; end
        sys_reset = 1'b0;
        mdl_reset();
        checks++; if (cuseen !== 0) begin errors++; $display("FAIL reset_no_update: got %0d exp 0", cuseen); end
        capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s !== mdl_stream() || fe !== 1 || cn !== 1) begin errors++; $display("FAIL post_reset_stream: got %h first=%0d cu=%0d exp %h 1 1", s, fe, cn, mdl_stream()); end
    endtask

    task automatic test_readback();
        logic pe; int bc, pn;
        issue_write(4'd4, 3'd1, 9'd9, pe, bc, pn);
        counter_type = 4'd4; counter_param = 3'd1; read_param = 1'b1;
        step();
        read_param = 1'b0;
`ifdef PLL_PARAM_RESPONDER_READBACK_EN
        mdl_dout = mdl[3];
        checks++; if (data_out !== 9'd9 || busy !== 1'b1 || param_error !== 1'b0) begin errors++; $display("FAIL readback_c0l: got dout=%0d busy=%b perr=%b exp 9 1 0", data_out, busy, param_error); end
        step();
        checks++; if (busy !== 1'b0 || data_out !== mdl_dout) begin errors++; $display("FAIL readback_hold: got busy=%b dout=%0d exp 0 %0d", busy, data_out, mdl_dout); end
        counter_type = 4'd3; counter_param = 3'd5; read_param = 1'b1;
        step();
        read_param = 1'b0; mdl_dout = '0;
        checks++; if (data_out !== 9'd0 || param_error !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL readback_bad: got dout=%0d perr=%b busy=%b exp 0 1 1", data_out, param_error, busy); end
        step();
`else
        checks++; if (data_out !== 9'd0 || busy !== 1'b0 || param_error !== 1'b0) begin errors++; $display("FAIL no_readback: got dout=%0d busy=%b perr=%b exp 0 0 0", data_out, busy, param_error); end
        step();
`endif
    endtask

    task automatic test_random();
        logic pe; int bc, pn, op, idx, gap;
        logic [3:0] t; logic [2:0] p; logic [8:0] d;
        logic [35:0] s; int nb, fe, le, cc, cn, ic, pc, v;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) valid_addr($urandom_range(0, 3), t, p);
            else begin t = 4'($urandom_range(0, 15)); p = 3'($urandom_range(0, 7)); end
            d = 9'($urandom_range(0, 511));
            idx = addr_idx(t, p);
            if (op <= 1) begin
                issue_write(t, p, d, pe, bc, pn);
                checks++; if (pe !== (idx < 0) || bc !== WB) begin errors++; $display("FAIL rnd_write: got perr=%b busy=%0d exp %b %0d", pe, bc, (idx < 0), WB); end
            end else if (op == 2) begin
                capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
                checks++; if (s !== mdl_stream() || cc !== 37 || ic !== 38 || v !== 0) begin errors++; $display("FAIL rnd_stream: got %h cu=%0d idle=%0d viol=%0d exp %h 37 38 0", s, cc, ic, v, mdl_stream()); end
            end else begin
                counter_type = t; counter_param = p; read_param = 1'b1;
                step();
                read_param = 1'b0;
`ifdef PLL_PARAM_RESPONDER_READBACK_EN
                mdl_dout = (idx >= 0) ? mdl[idx] : 9'd0;
                checks++; if (data_out !== mdl_dout || param_error !== (idx < 0) || busy !== 1'b1) begin errors++; $display("FAIL rnd_read: got dout=%h perr=%b busy=%b exp %h %b 1", data_out, param_error, busy, mdl_dout, (idx < 0)); end
                step();
`else
                checks++; if (data_out !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_read: got dout=%h busy=%b exp 0 0", data_out, busy); end
`endif
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
        end
        capture_reconfig(1'b0, 0, '0, '0, '0, s, nb, fe, le, cc, cn, ic, pc, v);
        checks++; if (s !== mdl_stream()) begin errors++; $display("FAIL rnd_final_stream: got %h exp %h", s, mdl_stream()); end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_default_stream();
        test_write_m();
        test_bad_write();
        test_busy_reject();
        test_back_to_back();
        test_priority();
        test_reset_mid_shift();
        test_readback();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
